// File: rtl/game_pkg.sv
// Shared definitions for the game datapath and its display path.
//
// Contents:
//   SCREEN_W, SCREEN_H   - screen geometry in pixels
//   SHIP_W, SHIP_H       - ship sprite size
//   GRID_BITS, IDX_W     - size of the packed occupancy grid and its index
//   *_COLOUR             - 3-bit colour constants used by the plotter
//   grid_index(x, y)     - linear bit position of pixel (x, y) in the grid
package game_pkg;

    localparam int SCREEN_W  = 160;
    localparam int SCREEN_H  = 120;
    localparam int SHIP_W    = 8;
    localparam int SHIP_H    = 4;
    localparam int GRID_BITS = SCREEN_W * SCREEN_H;
    localparam int IDX_W     = $clog2(GRID_BITS);

    typedef logic [2:0] colour_t;

    localparam colour_t BG_COLOUR    = 3'b000;
    localparam colour_t FG_COLOUR    = 3'b111;
    localparam colour_t USER_COLOUR  = 3'b010;
    localparam colour_t ENEMY_COLOUR = 3'b100;

    // Pixel (x, y) lives at bit y*SCREEN_W + x of the packed grid.
    function automatic int grid_index(input int px, input int py);
        return py * SCREEN_W + px;
    endfunction

endpackage

// File: rtl/grid_plotter_if.sv
// Bundle between the game datapath/control side and the grid plotter.
//
// Signals:
//   start    - frame request pulse (requester -> plotter)
//   grid     - packed occupancy, pixel (x,y) is bit y*SCREEN_W+x
//   user_x   - left column of the user ship
//   enemy_x  - left column of the enemy ship
//   x, y     - pixel coordinate of the current write (plotter -> adapter)
//   colour   - pixel colour
//   writeEn  - pixel write strobe
//   busy     - frame in progress
//   done     - one-cycle pulse after the last pixel
//
// Modports: master = requester side, slave = plotter side.
interface grid_plotter_if;
    import game_pkg::*;

    logic                 start;
    logic [GRID_BITS-1:0] grid;
    logic [7:0]           user_x;
    logic [7:0]           enemy_x;
    logic [7:0]           x;
    logic [6:0]           y;
    logic [2:0]           colour;
    logic                 writeEn;
    logic                 busy;
    logic                 done;

    modport master (
        output start, grid, user_x, enemy_x,
        input  x, y, colour, writeEn, busy, done
    );

    modport slave (
        input  start, grid, user_x, enemy_x,
        output x, y, colour, writeEn, busy, done
    );

endinterface

// File: rtl/raster_counter.sv
// Raster-order pixel counter.
//
// Ports:
//   clk, reset - clock and asynchronous active-low reset
//   clr        - synchronous clear of all counters (has priority over en)
//   en         - advance one pixel
//   cx, cy     - current column / row
//   idx        - linear pixel index, kept in step with cx/cy by increment
//   last       - current position is the final pixel (WIDTH-1, HEIGHT-1)
module raster_counter
    import game_pkg::*;
#(
    parameter int WIDTH  = SCREEN_W,
    parameter int HEIGHT = SCREEN_H
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clr,
    input  logic             en,
    output logic [7:0]       cx,
    output logic [6:0]       cy,
    output logic [IDX_W-1:0] idx,
    output logic             last
);

    localparam logic [7:0] CX_LAST = 8'(WIDTH - 1);
    localparam logic [6:0] CY_LAST = 7'(HEIGHT - 1);

    logic [7:0]       cx_q, cx_d;
    logic [6:0]       cy_q, cy_d;
    logic [IDX_W-1:0] idx_q, idx_d;

    assign last = (cx_q == CX_LAST) && (cy_q == CY_LAST);

    always_comb begin
        cx_d  = cx_q;
        cy_d  = cy_q;
        idx_d = idx_q;
        if (clr) begin
            cx_d  = '0;
            cy_d  = '0;
            idx_d = '0;
        end else if (en) begin
            if (cx_q == CX_LAST) begin
                cx_d = '0;
                cy_d = (cy_q == CY_LAST) ? '0 : cy_q + 7'd1;
            end else begin
                cx_d = cx_q + 8'd1;
            end
            // Linear index tracks the raster position without a multiplier.
            idx_d = last ? '0 : idx_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cx_q  <= '0;
            cy_q  <= '0;
            idx_q <= '0;
        end else begin
            cx_q  <= cx_d;
            cy_q  <= cy_d;
            idx_q <= idx_d;
        end
    end

    assign cx  = cx_q;
    assign cy  = cy_q;
    assign idx = idx_q;

endmodule

// File: rtl/grid_plotter.sv
// Draws one full frame of the packed occupancy grid to the VGA adapter's
// pixel-write port. On start the grid and both ship positions are
// snapshotted, then one pixel per clock is written in raster order with
// ships overlaid on top of the projectiles.
//
// Ports:
//   clk   - system clock
//   reset - asynchronous active-low reset
//   bus   - grid_plotter_if.slave: start/grid/user_x/enemy_x in,
//           x/y/colour/writeEn/busy/done out
//
// Timing: start sampled at edge N, first write visible after N+2, last
// write after N+1+WIDTH*HEIGHT, done pulses the cycle after the last write.
module grid_plotter
    import game_pkg::*;
#(
    parameter int      WIDTH        = SCREEN_W,
    parameter int      HEIGHT       = SCREEN_H,
    parameter int      SHIP_WIDTH   = SHIP_W,
    parameter int      SHIP_HEIGHT  = SHIP_H,
    parameter colour_t BG_C         = BG_COLOUR,
    parameter colour_t FG_C         = FG_COLOUR,
    parameter colour_t USER_C       = USER_COLOUR,
    parameter colour_t ENEMY_C      = ENEMY_COLOUR
) (
    input  logic          clk,
    input  logic          reset,
    grid_plotter_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SNAP = 2'd1,
        SCAN = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic [6:0] USER_ROW0  = 7'(HEIGHT - SHIP_HEIGHT);
    localparam logic [6:0] ENEMY_ROWS = 7'(SHIP_HEIGHT);
    localparam logic [8:0] SHIP_SPAN  = 9'(SHIP_WIDTH);

    state_t               state_q, state_d;
    logic [GRID_BITS-1:0] snap_grid_q, snap_grid_d;
    logic [7:0]           snap_ux_q, snap_ux_d;
    logic [7:0]           snap_ex_q, snap_ex_d;
    logic [7:0]           x_q, x_d;
    logic [6:0]           y_q, y_d;
    colour_t              colour_q, colour_d;
    logic                 we_q, we_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic             cnt_clr;
    logic             cnt_en;
    logic [7:0]       cx;
    logic [6:0]       cy;
    logic [IDX_W-1:0] idx;
    logic             last_pix;

    raster_counter #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_raster (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .cx    (cx),
        .cy    (cy),
        .idx   (idx),
        .last  (last_pix)
    );

    // Ship bounds in 9 bits: a ship near the right edge extends past
    // column WIDTH-1 instead of wrapping onto column 0.
    logic [8:0] cx_w;
    logic [8:0] ux_lo, ux_hi, ex_lo, ex_hi;
    logic       in_user, in_enemy;
    colour_t    pix_colour;

    always_comb begin
        cx_w     = {1'b0, cx};
        ux_lo    = {1'b0, snap_ux_q};
        ux_hi    = ux_lo + SHIP_SPAN;
        ex_lo    = {1'b0, snap_ex_q};
        ex_hi    = ex_lo + SHIP_SPAN;
        in_user  = (cy >= USER_ROW0) && (cx_w >= ux_lo) && (cx_w < ux_hi);
        in_enemy = (cy < ENEMY_ROWS) && (cx_w >= ex_lo) && (cx_w < ex_hi);
        if (in_user) begin
            pix_colour = USER_C;
        end else if (in_enemy) begin
            pix_colour = ENEMY_C;
        end else if (snap_grid_q[idx]) begin
            pix_colour = FG_C;
        end else begin
            pix_colour = BG_C;
        end
    end

    always_comb begin
        state_d     = state_q;
        snap_grid_d = snap_grid_q;
        snap_ux_d   = snap_ux_q;
        snap_ex_d   = snap_ex_q;
        x_d         = x_q;
        y_d         = y_q;
        colour_d    = colour_q;
        we_d        = 1'b0;
        cnt_clr     = 1'b0;
        cnt_en      = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = SNAP;
                end
            end
            SNAP: begin
                snap_grid_d = bus.grid;
                snap_ux_d   = bus.user_x;
                snap_ex_d   = bus.enemy_x;
                cnt_clr     = 1'b1;
                state_d     = SCAN;
            end
            SCAN: begin
                x_d      = cx;
                y_d      = cy;
                colour_d = pix_colour;
                we_d     = 1'b1;
                cnt_en   = 1'b1;
                if (last_pix) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        // busy covers SNAP through DONE; done trails the last write by one.
        busy_d = (state_d != IDLE);
        done_d = (state_q == DONE);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            snap_grid_q <= '0;
            snap_ux_q   <= '0;
            snap_ex_q   <= '0;
            x_q         <= '0;
            y_q         <= '0;
            colour_q    <= '0;
            we_q        <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            snap_grid_q <= snap_grid_d;
            snap_ux_q   <= snap_ux_d;
            snap_ex_q   <= snap_ex_d;
            x_q         <= x_d;
            y_q         <= y_d;
            colour_q    <= colour_d;
            we_q        <= we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end

    assign bus.x       = x_q;
    assign bus.y       = y_q;
    assign bus.colour  = colour_q;
    assign bus.writeEn = we_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

endmodule

// File: tb/tb_grid_plotter.sv
// Self-checking bench for grid_plotter: a pixel-level model (raster
// position from the write count, colour from the ship/grid priority rule
// on the snapshotted inputs) checked on every write, plus literal pixel
// expectations captured per frame.
module tb_grid_plotter;
    import game_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #10 clk = ~clk;

    grid_plotter_if bus ();

    grid_plotter dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_cmp = 0;
    int n_bad = 0;

    logic [GRID_BITS-1:0] snap_grid;
    int                   snap_ux = 0;
    int                   snap_ex = 0;
    bit                   exp_active = 1'b0;
    int                   exp_n = 0;
    int                   busy_cycles = 0;
    int                   done_cnt = 0;
    logic [2:0]           cap [SCREEN_H][SCREEN_W];

    function automatic void check(input string name, input longint act, input longint req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            if (n_bad <= 40)
                $display("FAIL %s: got %0d required %0d (write %0d)", name, act, req, exp_n);
        end
    endfunction

    // Expected colour from the priority rule, in plain integer arithmetic.
    function automatic logic [2:0] model_colour(input int px, input int py);
        if (py >= SCREEN_H - SHIP_H && px >= snap_ux && px <= snap_ux + SHIP_W - 1)
            return 3'b010;
        if (py < SHIP_H && px >= snap_ex && px <= snap_ex + SHIP_W - 1)
            return 3'b100;
        if (snap_grid[grid_index(px, py)])
            return 3'b111;
        return 3'b000;
    endfunction

    // Compare process: every write checked against the model.
    always @(negedge clk) begin
        if (reset) begin
            if (bus.busy) busy_cycles++;
            if (bus.writeEn) begin
                if (!exp_active || exp_n >= GRID_BITS) begin
                    check("unexpected_write", 1, 0);
                end else begin
                    check("pix_x", bus.x, exp_n % SCREEN_W);
                    check("pix_y", bus.y, exp_n / SCREEN_W);
                    check("pix_colour", bus.colour,
                          model_colour(exp_n % SCREEN_W, exp_n / SCREEN_W));
                    if (bus.x < SCREEN_W && bus.y < SCREEN_H)
                        cap[bus.y][bus.x] = bus.colour;
                    exp_n++;
                end
            end
            if (bus.done) begin
                done_cnt++;
                $display("frame done: writes=%0d busy_cycles=%0d", exp_n, busy_cycles);
                check("write_count", exp_n, GRID_BITS);
                check("busy_cycles", busy_cycles, GRID_BITS + 2);
                exp_active = 1'b0;
            end
        end
    end

    task automatic run_frame(input logic [GRID_BITS-1:0] g, input int ux, input int ex,
                             input bit isolate, input int abort_at);
        int waited;
        @(negedge clk);
        bus.grid    = g;
        bus.user_x  = 8'(ux);
        bus.enemy_x = 8'(ex);
        bus.start   = 1'b1;
        snap_grid   = g;
        snap_ux     = ux;
        snap_ex     = ex;
        exp_n       = 0;
        busy_cycles = 0;
        done_cnt    = 0;
        exp_active  = 1'b1;
        $display("frame start: ux=%0d ex=%0d isolate=%0d abort_at=%0d", ux, ex, isolate, abort_at);
        @(posedge clk); #1;
        bus.start = 1'b0;
        check("snap_busy", bus.busy, 1);
        check("snap_we", bus.writeEn, 0);
        @(posedge clk); #1;
        check("scan0_we", bus.writeEn, 0);
        @(posedge clk); #1;
        check("first_we", bus.writeEn, 1);
        check("first_xy", {bus.y, bus.x}, 0);
        if (isolate) begin
            repeat (2) @(posedge clk);
            #1;
            bus.grid    = '0;
            bus.user_x  = 8'd20;
            bus.enemy_x = 8'd60;
            for (int k = 0; k < 3; k++) begin
                repeat (100) @(posedge clk);
                #1 bus.start = 1'b1;
                @(posedge clk);
                #1 bus.start = 1'b0;
            end
        end
        if (abort_at > 0) begin
            waited = 0;
            while (exp_n < abort_at && waited < GRID_BITS) begin
                @(negedge clk);
                waited++;
            end
            #2;
            exp_active = 1'b0;
            reset      = 1'b0;
            #1;
            $display("abort at write %0d", exp_n);
            check("abort_we", bus.writeEn, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_xyc", {bus.colour, bus.y, bus.x}, 0);
            check("abort_done", bus.done, 0);
            repeat (3) @(negedge clk);
            reset = 1'b1;
            repeat (10) @(negedge clk);
            #1 check("after_abort_busy", bus.busy, 0);
        end else begin
            waited = 0;
            while (done_cnt == 0 && waited < GRID_BITS + 100) begin
                @(negedge clk);
                #1 waited++;
            end
            if (done_cnt == 0) check("done_timeout", 0, 1);
            repeat (10) @(negedge clk);
            #1;
            check("done_pulses", done_cnt, 1);
            check("idle_busy", bus.busy, 0);
            check("idle_we", bus.writeEn, 0);
        end
    endtask

    logic [GRID_BITS-1:0] g;

    initial begin
        bus.start   = 1'b0;
        bus.grid    = '0;
        bus.user_x  = '0;
        bus.enemy_x = '0;
        #1;
        check("rst_we", bus.writeEn, 0);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_xyc", {bus.colour, bus.y, bus.x}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);

        // Empty grid, both ships at column 0.
        run_frame('0, 0, 0, 1'b0, 0);
        check("f1_enemy_00", cap[0][0], 3'b100);
        check("f1_enemy_73", cap[3][7], 3'b100);
        check("f1_bg_04", cap[4][0], 3'b000);
        check("f1_user_7_119", cap[119][7], 3'b010);
        check("f1_bg_8_119", cap[119][8], 3'b000);

        // Single projectile plus one hidden under the user ship.
        g = '0;
        g[grid_index(37, 20)] = 1'b1;
        g[grid_index(50, 118)] = 1'b1;
        run_frame(g, 48, 100, 1'b0, 0);
        check("f2_shot", cap[20][37], 3'b111);
        check("f2_shot_nb", cap[20][36], 3'b000);
        check("f2_prio", cap[118][50], 3'b010);
        check("f2_enemy_100", cap[0][100], 3'b100);
        check("f2_enemy_107", cap[3][107], 3'b100);
        check("f2_bg_108", cap[0][108], 3'b000);
        check("f2_bg_47_116", cap[116][47], 3'b000);

        // All-ones snapshot cleared mid-frame, user ship clipped at the edge.
        g = '1;
        run_frame(g, 157, 3, 1'b1, 0);
        check("f3_noclip_0", cap[116][0], 3'b111);
        check("f3_clip_157", cap[119][157], 3'b010);
        check("f3_clip_159", cap[116][159], 3'b010);
        check("f3_fg_mid", cap[50][80], 3'b111);
        check("f3_enemy", cap[0][3], 3'b100);

        // Random frame aborted by reset, then a fresh random frame.
        for (int i = 0; i < GRID_BITS; i++) g[i] = ($urandom_range(0, 5) == 0);
        run_frame(g, $urandom_range(0, 200), $urandom_range(0, 200), 1'b0, 5000);
        for (int i = 0; i < GRID_BITS; i++) g[i] = ($urandom_range(0, 3) == 0);
        run_frame(g, $urandom_range(0, 170), $urandom_range(0, 170), 1'b0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
